// File: rtl/ff_pkg.sv
// Shared definitions for the field-arithmetic blocks.
//   P25519            : Curve25519 prime, 2^255 - 19
//   ff_op_e           : add / sub selector
//   ff_addsub_state_e : limb-serial add/sub sequencer states
//   ceil_div          : integer ceiling division, used to size limb counts
package ff_pkg;

  localparam logic [254:0] P25519 = 255'((256'd1 << 255) - 256'd19);

  typedef enum logic {
    FF_ADD = 1'b0,
    FF_SUB = 1'b1
  } ff_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    SEL,
    DONE
  } ff_addsub_state_e;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/ff_limb_addsub.sv
// One limb of the two parallel carry chains used by ff_addsub_serial.
//   i_a_k, i_b_k, i_p_k : operand and modulus limbs
//   i_op                : FF_ADD or FF_SUB
//   i_c1, i_c2          : incoming carry/borrow of chain 1 / chain 2
//   o_s_k, o_c1         : chain 1, a +/- b
//   o_t_k, o_c2         : chain 2, s - P (add) or s + P (sub)
// Purely combinational.
module ff_limb_addsub
  import ff_pkg::*;
#(
  parameter int unsigned LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] i_a_k,
  input  logic [LIMB_W-1:0] i_b_k,
  input  logic [LIMB_W-1:0] i_p_k,
  input  ff_op_e            i_op,
  input  logic              i_c1,
  input  logic              i_c2,
  output logic [LIMB_W-1:0] o_s_k,
  output logic [LIMB_W-1:0] o_t_k,
  output logic              o_c1,
  output logic              o_c2
);

  // One extra bit on top holds the carry (add) or the borrow (sub, sign of the difference).
  logic [LIMB_W:0] w_ch1;
  logic [LIMB_W:0] w_ch2;

  always_comb begin
    w_ch1 = '0;
    w_ch2 = '0;
    if (i_op == FF_ADD) begin
      w_ch1 = {1'b0, i_a_k} + {1'b0, i_b_k} + {{LIMB_W{1'b0}}, i_c1};
      w_ch2 = {1'b0, w_ch1[LIMB_W-1:0]} - {1'b0, i_p_k} - {{LIMB_W{1'b0}}, i_c2};
    end else begin
      w_ch1 = {1'b0, i_a_k} - {1'b0, i_b_k} - {{LIMB_W{1'b0}}, i_c1};
      w_ch2 = {1'b0, w_ch1[LIMB_W-1:0]} + {1'b0, i_p_k} + {{LIMB_W{1'b0}}, i_c2};
    end
  end

  assign o_s_k = w_ch1[LIMB_W-1:0];
  assign o_c1  = w_ch1[LIMB_W];
  assign o_t_k = w_ch2[LIMB_W-1:0];
  assign o_c2  = w_ch2[LIMB_W];

endmodule

// File: rtl/ff_addsub_serial.sv
// Limb-serial modular adder/subtractor over GF(P).
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   : request handshake (i_op, i_a, i_b, i_tag)
//   o_out_valid / i_out_ready : result handshake (o_result, o_out_tag)
//   o_busy                    : high whenever the sequencer is not idle
// Operands are processed LSB limb first, one LIMB_W-bit limb per cycle. Both a +/- b and
// the P-corrected value are built in parallel; one cycle of selection picks the canonical one.
module ff_addsub_serial
  import ff_pkg::*;
#(
  parameter int unsigned      WIDTH  = 255,
  parameter logic [WIDTH-1:0] P      = WIDTH'(P25519),
  parameter int unsigned      LIMB_W = 64,
  parameter int unsigned      TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_busy
);

  localparam int unsigned NUM_LIMBS = ceil_div(WIDTH, LIMB_W);
  localparam int unsigned EXT_W     = NUM_LIMBS * LIMB_W;
  localparam int unsigned CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [EXT_W-1:0]  P_EXT    = EXT_W'(P);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_LIMBS - 1);

  ff_addsub_state_e r_state;
  ff_op_e           r_op;
  logic [EXT_W-1:0] r_a, r_b, r_s, r_t;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c1, r_c2;
  logic [TAG_W-1:0] r_tag;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_out_tag;

  logic [LIMB_W-1:0] w_p_k, w_s_k, w_t_k;
  logic              w_c1, w_c2;
  logic              w_accept;
  logic              w_sel_t;

  assign w_p_k = P_EXT[r_cnt * LIMB_W +: LIMB_W];

  ff_limb_addsub #(
    .LIMB_W (LIMB_W)
  ) u_limb (
    .i_a_k (r_a[LIMB_W-1:0]),
    .i_b_k (r_b[LIMB_W-1:0]),
    .i_p_k (w_p_k),
    .i_op  (r_op),
    .i_c1  (r_c1),
    .i_c2  (r_c2),
    .o_s_k (w_s_k),
    .o_t_k (w_t_k),
    .o_c1  (w_c1),
    .o_c2  (w_c2)
  );

  // i_out_ready reaches outputs only through o_in_ready while DONE.
  always_comb begin
    o_in_ready = 1'b0;
    unique case (r_state)
      IDLE:    o_in_ready = 1'b1;
      DONE:    o_in_ready = i_out_ready;
      default: o_in_ready = 1'b0;
    endcase
  end

  assign w_accept = i_in_valid & o_in_ready;

  // Add: a carry out of the padded width or no borrow from s - P means s >= P.
  // Sub: a borrow from a - b means the result must be wrapped by +P.
  assign w_sel_t = (r_op == FF_ADD) ? (r_c1 | ~r_c2) : r_c1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_op        <= FF_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_t         <= '0;
      r_cnt       <= '0;
      r_c1        <= 1'b0;
      r_c2        <= 1'b0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
    end else begin
      unique case (r_state)
        IDLE: ;
        SUM: begin
          r_a   <= r_a >> LIMB_W;
          r_b   <= r_b >> LIMB_W;
          // New limbs enter at the top so limb 0 ends at the bottom after NUM_LIMBS shifts.
          r_s   <= (r_s >> LIMB_W) | (EXT_W'(w_s_k) << (EXT_W - LIMB_W));
          r_t   <= (r_t >> LIMB_W) | (EXT_W'(w_t_k) << (EXT_W - LIMB_W));
          r_c1  <= w_c1;
          r_c2  <= w_c2;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= SEL;
          end
        end
        SEL: begin
          r_result    <= w_sel_t ? r_t[WIDTH-1:0] : r_s[WIDTH-1:0];
          r_out_tag   <= r_tag;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Accept overrides the state update above (covers the DONE -> SUM back-to-back path).
      if (w_accept) begin
        r_op    <= ff_op_e'(i_op);
        r_a     <= EXT_W'(i_a);
        r_b     <= EXT_W'(i_b);
        r_tag   <= i_tag;
        r_cnt   <= '0;
        r_c1    <= 1'b0;
        r_c2    <= 1'b0;
        r_state <= SUM;
      end
    end
  end

  if (EXT_W > WIDTH) begin : g_pad
    // Padding bits above WIDTH are always dropped from the result.
    logic w_pad_unused;
    assign w_pad_unused = ^{r_s[EXT_W-1:WIDTH], r_t[EXT_W-1:WIDTH]};
  end

  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_out_tag   = r_out_tag;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ff_addsub_serial.sv
// Directed bench for ff_addsub_serial: default 255-bit instance plus an 8-bit, 3-limb variant.
module tb_ff_addsub_serial;
  import ff_pkg::*;

  localparam logic [255:0] PP = (256'd1 << 255) - 256'd19;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic         in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [254:0] a, b, result;
  logic [3:0]   tag, out_tag;

  // Variant instance: WIDTH=8, P=251, LIMB_W=3
  logic       v_in_valid, v_in_ready, v_op, v_out_valid, v_out_ready, v_busy;
  logic [7:0] v_a, v_b, v_result;
  logic [3:0] v_tag, v_out_tag;

  int n_vec = 0;
  int n_err = 0;

  ff_addsub_serial u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .i_tag       (tag),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_out_tag   (out_tag),
    .o_busy      (busy)
  );

  ff_addsub_serial #(
    .WIDTH  (8),
    .P      (8'd251),
    .LIMB_W (3),
    .TAG_W  (4)
  ) u_var (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (v_in_valid),
    .o_in_ready  (v_in_ready),
    .i_op        (v_op),
    .i_a         (v_a),
    .i_b         (v_b),
    .i_tag       (v_tag),
    .o_out_valid (v_out_valid),
    .i_out_ready (v_out_ready),
    .o_result    (v_result),
    .o_out_tag   (v_out_tag),
    .o_busy      (v_busy)
  );

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Present a request while the DUT is idle; returns just after the accepting edge.
  task automatic start(input bit v, input logic o, input logic [255:0] xa, input logic [255:0] xb,
                       input logic [3:0] xt, input string name);
    @(negedge clk);
    chk({name, "/in_ready"}, v ? 256'(v_in_ready) : 256'(in_ready), 256'd1);
    if (v) begin
      v_in_valid = 1'b1; v_op = o; v_a = xa[7:0]; v_b = xb[7:0]; v_tag = xt;
    end else begin
      in_valid = 1'b1; op = o; a = xa[254:0]; b = xb[254:0]; tag = xt;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    v_in_valid = 1'b0;
  endtask

  // Called just after the accepting edge: count edges until out_valid, then check the payload.
  task automatic wait_result(input bit v, input int exp_lat, input logic [255:0] exp_res,
                             input logic [3:0] exp_tag, input string name);
    int lat = 0;
    while (!(v ? v_out_valid : out_valid) && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "/latency"}, 256'(lat), 256'(exp_lat));
    chk({name, "/result"}, v ? 256'(v_result) : 256'(result), exp_res);
    chk({name, "/tag"}, v ? 256'(v_out_tag) : 256'(out_tag), 256'(exp_tag));
  endtask

  task automatic consume(input bit v, input string name);
    @(negedge clk);
    if (v) v_out_ready = 1'b1; else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready   = 1'b0;
    v_out_ready = 1'b0;
    chk({name, "/valid_clr"}, v ? 256'(v_out_valid) : 256'(out_valid), 256'd0);
    chk({name, "/busy_clr"}, v ? 256'(v_busy) : 256'(busy), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; tag = '0; out_ready = 1'b0;
    v_in_valid = 1'b0; v_op = 1'b0; v_a = '0; v_b = '0; v_tag = '0; v_out_ready = 1'b0;
    #1;
    chk("rst/out_valid", 256'(out_valid), 256'd0);
    chk("rst/result", 256'(result), 256'd0);
    chk("rst/out_tag", 256'(out_tag), 256'd0);
    chk("rst/busy", 256'(busy), 256'd0);
    chk("rst/in_ready", 256'(in_ready), 256'd1);
    #11;
    rst_n = 1'b1;

    // Basic add with latency check
    start(0, 1'b0, 256'd10, 256'd20, 4'd3, "add10_20");
    chk("add10_20/busy", 256'(busy), 256'd1);
    wait_result(0, 5, 256'd30, 4'd3, "add10_20");
    consume(0, "add10_20");

    // Add wrap-around and no-wrap boundaries
    start(0, 1'b0, PP - 1, 256'd4686, 4'd1, "add_pm1_4686");
    wait_result(0, 5, 256'd4685, 4'd1, "add_pm1_4686");
    consume(0, "add_pm1_4686");
    start(0, 1'b0, PP - 1, 256'd1, 4'd2, "add_pm1_1");
    wait_result(0, 5, 256'd0, 4'd2, "add_pm1_1");
    consume(0, "add_pm1_1");
    start(0, 1'b0, 256'd1 << 254, 256'd1, 4'd4, "add_2p254_1");
    wait_result(0, 5, (256'd1 << 254) + 256'd1, 4'd4, "add_2p254_1");
    consume(0, "add_2p254_1");

    // Subtraction
    start(0, 1'b1, 256'd5, 256'd7, 4'd7, "sub5_7");
    wait_result(0, 5, PP - 2, 4'd7, "sub5_7");
    consume(0, "sub5_7");
    start(0, 1'b1, 256'd0, 256'd0, 4'd8, "sub0_0");
    wait_result(0, 5, 256'd0, 4'd8, "sub0_0");
    consume(0, "sub0_0");
    start(0, 1'b1, PP - 1, 256'd0, 4'd9, "sub_pm1_0");
    wait_result(0, 5, PP - 1, 4'd9, "sub_pm1_0");
    consume(0, "sub_pm1_0");

    // Backpressure, then back-to-back accept from DONE
    start(0, 1'b0, 256'd100, 256'd23, 4'd5, "bp");
    wait_result(0, 5, 256'd123, 4'd5, "bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp/hold_valid", 256'(out_valid), 256'd1);
      chk("bp/hold_result", 256'(result), 256'd123);
      chk("bp/hold_tag", 256'(out_tag), 256'd5);
      chk("bp/hold_in_ready", 256'(in_ready), 256'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 1'b0; a = 255'd1; b = 255'd1; tag = 4'd6;
    #1;
    chk("b2b/in_ready", 256'(in_ready), 256'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b/valid_clr", 256'(out_valid), 256'd0);
    chk("b2b/busy", 256'(busy), 256'd1);
    wait_result(0, 5, 256'd2, 4'd6, "b2b");
    consume(0, "b2b");

    // Reset during the second SUM cycle aborts the operation
    start(0, 1'b0, 256'd50, 256'd60, 4'd10, "abort");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort/in_ready", 256'(in_ready), 256'd1);
    chk("abort/busy", 256'(busy), 256'd0);
    chk("abort/valid", 256'(out_valid), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort/no_valid", 256'(seen), 256'd0);
    chk("abort/busy_after", 256'(busy), 256'd0);
    start(0, 1'b1, 256'd9, 256'd4, 4'd11, "sub9_4");
    wait_result(0, 5, 256'd5, 4'd11, "sub9_4");
    consume(0, "sub9_4");

    // Variant instance: padded width 9, three 3-bit limbs
    start(1, 1'b0, 256'd250, 256'd250, 4'd1, "v_add250_250");
    wait_result(1, 4, 256'd249, 4'd1, "v_add250_250");
    consume(1, "v_add250_250");
    start(1, 1'b1, 256'd3, 256'd10, 4'd2, "v_sub3_10");
    wait_result(1, 4, 256'd244, 4'd2, "v_sub3_10");
    consume(1, "v_sub3_10");
    start(1, 1'b0, 256'd0, 256'd0, 4'd3, "v_add0_0");
    wait_result(1, 4, 256'd0, 4'd3, "v_add0_0");
    consume(1, "v_add0_0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ff_addsub_serial.md
Name: ff_addsub_serial

Overview:
- Parametrised, limb-serial modular adder/subtractor over GF(P).
- Successor to the single-width, add-only field adder. Adds configurable width, modulus and limb size, an add/sub mode, a valid/ready handshake on both sides, and a passthrough tag.
- Sits between the scalar-multiplication point-arithmetic sequencer and the field multiplier. Trades latency for a LIMB_W-wide datapath.

Parameters:
- WIDTH, 255: field element width in bits.
- P, 2^255-19: modulus. Must satisfy 2^(WIDTH-1) < P < 2^WIDTH.
- LIMB_W, 64: bits processed per cycle.
- TAG_W, 4: width of the caller tag carried with each operation.
- NUM_LIMBS (localparam), ceil(WIDTH/LIMB_W): limbs per operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  1  0 = add (a+b mod P), 1 = sub (a-b mod P).
- a  in  WIDTH  operand, required < P.
- b  in  WIDTH  operand, required < P.
- tag  in  TAG_W  caller tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  canonical residue in [0, P-1].
- out_tag  out  TAG_W  tag of the operation producing result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state = IDLE, out_valid = 0, result = 0, out_tag = 0, busy = 0.
  - Internal limb counter, carry/borrow flags and shift registers cleared.
  - in_ready = 1 once state is IDLE.
- Arithmetic is performed on NUM_LIMBS*LIMB_W bits. Operands and P are zero-extended; result is truncated to WIDTH.
- States:
  - IDLE: in_ready = 1. A transfer occurs when in_valid and in_ready are both high. On transfer, latch op, a, b and tag; clear the counter and both chain flags; go to SUM.
  - SUM: one limb per cycle, LSB first. Two chains run in parallel on limb k:
    - Chain 1: s_k = a_k ± b_k with carry/borrow c1.
    - Chain 2, add mode: t_k = s_k - P_k with borrow c2.
    - Chain 2, sub mode: t_k = s_k + P_k with carry c2.
    - s_k and t_k shift into s_reg and t_reg.
    - After limb NUM_LIMBS-1, go to SEL.
  - SEL (1 cycle): select the result, then set out_valid = 1, drive out_tag, go to DONE.
    - Add: result = t when (c1 | ~c2), otherwise s. The final c1 is the carry out of the extended width.
    - Sub: result = t when c1 (a borrow occurred), otherwise s.
  - DONE: result and out_tag stay stable while out_valid && !out_ready.
    - When out_ready = 1: clear out_valid. If in_valid is also high, accept the new request in the same cycle and go to SUM; otherwise go to IDLE.
    - in_ready = out_ready in this state (combinational), so back-to-back operations need no bubble.
- Latency: out_valid rises on the edge NUM_LIMBS+1 cycles after the accepting edge (5 cycles for the defaults).
- Throughput: one operation per NUM_LIMBS+2 cycles when out_ready is held high.
- Exactly one operation is outstanding at a time. in_ready is low throughout SUM and SEL.
- Operands ≥ P give an unspecified result; no error flag is raised.
- Reset asserted mid-operation aborts it: no out_valid is produced and nothing of the aborted operation persists.
- The block must not combinationally depend on out_ready except through in_ready in DONE.

Decomposition:
- Package ff_pkg holds:
  - Constant P25519 = 2^255-19.
  - Typedef ff_op_e {FF_ADD, FF_SUB}.
  - Typedef ff_addsub_state_e {IDLE, SUM, SEL, DONE}.
  - Function ceil_div for NUM_LIMBS.
- One sub-module, ff_limb_addsub: purely combinational, one limb wide. Inputs: a_k, b_k, P_k, op, c1_in, c2_in. Outputs: s_k, t_k, c1_out, c2_out. It is instantiated once and reused every SUM cycle.

Test Plan:
- Defaults, op=add, a=10, b=20, tag=3 → result=30, out_tag=3. out_valid is high exactly 5 cycles after the accept edge.
- op=add, a=P-1, b=4686 → 4685. Then op=add, a=P-1, b=1 → 0. Then op=add, a=2^254, b=1 → 2^254+1.
- op=sub, a=5, b=7 → P-2. Then op=sub, a=0, b=0 → 0. Then op=sub, a=P-1, b=0 → P-1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid → result and out_tag stable, in_ready=0.
  - Then raise out_ready together with in_valid (add 1+1) → second request accepted that cycle; second result 2 appears 5 cycles later.
- Reset mid-op: drive rst low during the 2nd SUM cycle of an add, release → out_valid never pulses, in_ready=1, busy=0. A following sub 9-4 returns 5.
- Variant WIDTH=8, P=251, LIMB_W=3 (NUM_LIMBS=3, padded width 9):
  - add 250+250 → 249.
  - sub 3-10 → 244.
  - add 0+0 → 0.
  - Latency 4 cycles.
